mode_controller: RTL and testbench

Front-panel sequencer for the board top level. Debounces the power, confirm, select and exit keys and detects a long press on power. Runs the power/menu/active state machine that owns the one-hot mode selection and the `mode_entered` flag consumed by the display mux and the four mode sub-blocks (calculator, study, competition, display). Forwards clean single-cycle key pulses to the active sub-block and emits a beep request for the buzzer.

---
 rtl/mode_ctrl_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 44 ++++
 rtl/mode_controller.sv | 134 +++++++++++++
 tb/tb_mode_controller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mode_ctrl_pkg.sv
// Shared types and constants for the front-panel mode sequencer.
package mode_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    MENU   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] MODE1 = 4'b0001;
  localparam logic [3:0] MODE2 = 4'b0010;
  localparam logic [3:0] MODE3 = 4'b0100;
  localparam logic [3:0] MODE4 = 4'b1000;

  localparam int unsigned KEY_CONFIRM = 0;
  localparam int unsigned KEY_SELECT  = 1;
  localparam int unsigned KEY_EXIT    = 2;
  localparam int unsigned KEY_POWER   = 3;

  // One-hot rotate left, MODE4 wraps back to MODE1.
  function automatic logic [3:0] next_mode(input logic [3:0] m);
    return {m[2:0], m[3]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Key conditioner: 2-FF synchronizer, stable-count debounce, rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync      <= '0;
      cnt       <= '0;
      key_level <= 1'b0;
      level_q   <= 1'b0;
      key_rise  <= 1'b0;
    end else begin
      sync     <= {sync[0], key_raw};
      level_q  <= key_level;
      key_rise <= key_level & ~level_q;
      // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
      if (sync[1] != key_level) begin
        if (cnt == CNT_LAST) begin
          key_level <= ~key_level;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mode_controller.sv
// Front-panel sequencer: debounced keys, power long-press, OFF/MENU/ACTIVE FSM
// owning the one-hot mode selection, key forwarding and beep requests.
module mode_controller
  import mode_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 2_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 300_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_button,
  input  logic       confirm,
  input  logic       select,
  input  logic       exit,
  input  logic [3:0] sub_busy,
  output logic       power_on,
  output logic [3:0] mode_sel,
  output logic       mode_entered,
  output logic [2:0] key_pulse,
  output logic       key_beep
);

  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic [3:0]    raw_keys;
  logic [3:0]    key_level;
  logic [3:0]    key_rise;
  logic          pwr_level;
  logic          unused_key_level;

  logic [HW-1:0] hold_cnt;
  logic          long_evt;
  logic          lock;

  state_t        state, state_d;
  logic [3:0]    mode_sel_d;
  logic          beep_d;
  logic [2:0]    key_pulse_d;
  logic          mode_busy;

  assign raw_keys = {power_button, exit, select, confirm};

  for (genvar i = 0; i < 4; i++) begin : g_key
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .key_raw  (raw_keys[i]),
      .key_level(key_level[i]),
      .key_rise (key_rise[i])
    );
  end

  assign pwr_level        = key_level[KEY_POWER];
  assign unused_key_level = ^key_level[KEY_EXIT:KEY_CONFIRM];
  assign mode_busy        = |(sub_busy & mode_sel);

  // hold_cnt saturates, so long_evt can fire only once per press; lock outlives it
  // until the debounced key is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      long_evt <= 1'b0;
      lock     <= 1'b0;
    end else if (!pwr_level) begin
      hold_cnt <= '0;
      long_evt <= 1'b0;
      lock     <= 1'b0;
    end else begin
      if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
      long_evt <= (hold_cnt == HOLD_LAST);
      if (long_evt) lock <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state;
    mode_sel_d  = mode_sel;
    beep_d      = 1'b0;
    key_pulse_d = '0;
    case (state)
      OFF: begin
        if (key_rise[KEY_POWER] && !lock) begin
          state_d    = MENU;
          mode_sel_d = MODE1;
          beep_d     = 1'b1;
        end
      end
      MENU: begin
        if (long_evt) begin
          state_d = OFF;
        end else if (key_rise[KEY_CONFIRM]) begin
          state_d = ACTIVE;
          beep_d  = 1'b1;
        end else if (key_rise[KEY_SELECT]) begin
          mode_sel_d = next_mode(mode_sel);
          beep_d     = 1'b1;
        end
      end
      ACTIVE: begin
        if (long_evt) begin
          state_d = OFF;
        end else if (key_rise[KEY_EXIT] && !mode_busy) begin
          state_d = MENU;
          beep_d  = 1'b1;
        end
      end
      default: state_d = OFF;
    endcase
    if (state != OFF && state_d != OFF) key_pulse_d = key_rise[KEY_EXIT:KEY_CONFIRM];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= OFF;
      mode_sel     <= MODE1;
      power_on     <= 1'b0;
      mode_entered <= 1'b0;
      key_pulse    <= '0;
      key_beep     <= 1'b0;
    end else begin
      state        <= state_d;
      mode_sel     <= mode_sel_d;
      power_on     <= (state_d != OFF);
      mode_entered <= (state_d == ACTIVE);
      key_pulse    <= key_pulse_d;
      key_beep     <= beep_d;
    end
  end

endmodule

// File: tb/tb_mode_controller.sv
// Directed bench for mode_controller; key events are checked against a queue of expected output snapshots.
module tb_mode_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] raw = '0;
  logic [3:0] sub_busy = '0;

  logic       power_on;
  logic [3:0] mode_sel;
  logic       mode_entered;
  logic [2:0] key_pulse;
  logic       key_beep;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  mode_controller #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .power_button(raw[3]),
    .confirm     (raw[0]),
    .select      (raw[1]),
    .exit        (raw[2]),
    .sub_busy    (sub_busy),
    .power_on    (power_on),
    .mode_sel    (mode_sel),
    .mode_entered(mode_entered),
    .key_pulse   (key_pulse),
    .key_beep    (key_beep)
  );

  // Snapshot layout: {beep, power_on, mode_entered, mode_sel[3:0], key_pulse[2:0]}
  function automatic logic [9:0] mk(input logic b, input logic p, input logic e,
                                    input logic [3:0] m, input logic [2:0] k);
    return {b, p, e, m, k};
  endfunction

  function automatic logic [9:0] snap();
    return {key_beep, power_on, mode_entered, mode_sel, key_pulse};
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] m, input int unsigned hold);
    raw = raw | m;
    repeat (hold) @(posedge clk);
    #1 raw = raw & ~m;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic steady(input string tag, input logic [9:0] exp);
    @(negedge clk);
    check(tag, snap(), exp);
  endtask

  // Any beep or forwarded key consumes one expected snapshot.
  always @(negedge clk) begin
    if (reset === 1'b1 && (key_beep !== 1'b0 || key_pulse !== 3'b000)) begin
      checks++;
      assert (exp_q.size() != 0)
      else begin
        failures++;
        $error("FAIL unexpected_event observed=%b expected=none", snap());
      end
      if (exp_q.size() != 0) check("event", snap(), exp_q.pop_front());
    end
  end

  initial begin
    logic [3:0] sel_seq[4];
    sel_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_vals", snap(), mk(0, 0, 0, 4'b0001, 3'b000));
    @(posedge clk);
    #1 reset = 1'b1;

    press(4'b0001, 10);
    steady("off_ignores_confirm", mk(0, 0, 0, 4'b0001, 3'b000));

    exp_q.push_back(mk(1, 1, 0, 4'b0001, 3'b000));
    raw[3] = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("pon_cycle7", snap(), mk(0, 0, 0, 4'b0001, 3'b000));
    @(posedge clk);
    @(negedge clk);
    check("pon_cycle8", snap(), mk(1, 1, 0, 4'b0001, 3'b000));
    @(posedge clk);
    #1 raw[3] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    steady("menu_idle", mk(0, 1, 0, 4'b0001, 3'b000));

    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1, 1, 0, sel_seq[i], 3'b010));
      press(4'b0010, 10);
    end
    steady("menu_after_selects", mk(0, 1, 0, 4'b0001, 3'b000));

    press(4'b0001, 2);
    steady("glitch_ignored", mk(0, 1, 0, 4'b0001, 3'b000));

    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(1, 1, 0, sel_seq[i], 3'b010));
      press(4'b0010, 10);
    end
    exp_q.push_back(mk(1, 1, 1, 4'b0100, 3'b001));
    press(4'b0001, 10);
    steady("active_mode3", mk(0, 1, 1, 4'b0100, 3'b000));

    sub_busy = 4'b0100;
    exp_q.push_back(mk(0, 1, 1, 4'b0100, 3'b100));
    press(4'b0100, 10);
    steady("busy_exit_held", mk(0, 1, 1, 4'b0100, 3'b000));

    sub_busy = 4'b1011;
    exp_q.push_back(mk(1, 1, 0, 4'b0100, 3'b100));
    press(4'b0100, 10);
    steady("exit_to_menu", mk(0, 1, 0, 4'b0100, 3'b000));
    sub_busy = 4'b0000;

    exp_q.push_back(mk(1, 1, 1, 4'b0100, 3'b001));
    press(4'b0001, 10);
    exp_q.push_back(mk(0, 1, 1, 4'b0100, 3'b010));
    press(4'b0010, 10);
    press(4'b1000, 10);
    steady("short_power_no_effect", mk(0, 1, 1, 4'b0100, 3'b000));

    raw[3] = 1'b1;
    repeat (56) @(posedge clk);
    @(negedge clk);
    check("long_cycle56", snap(), mk(0, 1, 1, 4'b0100, 3'b000));
    @(posedge clk);
    @(negedge clk);
    check("long_cycle57", snap(), mk(0, 0, 0, 4'b0100, 3'b000));
    raw[0] = 1'b1;
    repeat (12) @(posedge clk);
    #1 raw = '0;
    repeat (14) @(posedge clk);
    #1;
    steady("no_repower", mk(0, 0, 0, 4'b0100, 3'b000));

    exp_q.push_back(mk(1, 1, 0, 4'b0001, 3'b000));
    press(4'b1000, 10);
    steady("repower_menu", mk(0, 1, 0, 4'b0001, 3'b000));

    exp_q.push_back(mk(1, 1, 1, 4'b0001, 3'b011));
    press(4'b0011, 10);
    steady("confirm_beats_select", mk(0, 1, 1, 4'b0001, 3'b000));

    @(posedge clk);
    #1 reset = 1'b0;
    #1 check("async_reset", snap(), mk(0, 0, 0, 4'b0001, 3'b000));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    exp_q.push_back(mk(1, 1, 0, 4'b0001, 3'b000));
    press(4'b1000, 10);
    steady("resume_after_reset", mk(0, 1, 0, 4'b0001, 3'b000));

    repeat (5) @(posedge clk);
    check("queue_empty", 10'(exp_q.size()), 10'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
